// File: rtl/spi_flash_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of flash_ctrl.
// Holds one level request into flash_ctrl until f_ack. Returns a one-cycle
// ack (with err and read data) to the granted client. A watchdog aborts
// operations that never see f_ack.
module spi_flash_arbiter #(
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        c0_req,
  input  logic [1:0]  c0_cmd,
  input  logic [23:0] c0_addr,
  input  logic [7:0]  c0_wdata,
  output logic        c0_ack,
  output logic        c0_err,
  output logic [7:0]  c0_rdata,
  input  logic        c1_req,
  input  logic [1:0]  c1_cmd,
  input  logic [23:0] c1_addr,
  input  logic [7:0]  c1_wdata,
  output logic        c1_ack,
  output logic        c1_err,
  output logic [7:0]  c1_rdata,
  output logic        f_rd_req,
  output logic        f_pp_req,
  output logic        f_se_req,
  output logic        f_be_req,
  output logic [23:0] f_rd_addr,
  output logic [23:0] f_wr_addr,
  output logic [23:0] f_se_addr,
  output logic [7:0]  f_wdata,
  input  logic [7:0]  f_rdata,
  input  logic        f_ack,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_t;

  localparam logic [1:0]      CMD_READ = 2'd0;
  localparam logic [TO_W-1:0] LP_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0] LP_LAST  = TIMEOUT - LP_ONE;

  state_t          r_state;
  state_t          w_next;
  logic            w_any_req;
  logic            w_sel;
  logic            w_timeout;
  logic [TO_W-1:0] r_cnt;
  logic            r_ptr;
  logic            r_gid;
  logic            r_busy;
  logic [1:0]      r_cmd;
  logic [23:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [3:0]      r_f_req;   // {be, se, pp, rd}
  logic [23:0]     r_f_addr;
  logic [7:0]      r_f_wdata;
  logic [1:0]      r_ack;
  logic [1:0]      r_err;
  logic [7:0]      r_rdata0;
  logic [7:0]      r_rdata1;

  // A lone requester wins outright; under contention the pointer decides.
  assign w_any_req = c0_req | c1_req;
  assign w_sel     = (c0_req & c1_req) ? r_ptr : c1_req;
  assign w_timeout = (r_cnt == LP_LAST);

  assign c0_ack    = r_ack[0];
  assign c1_ack    = r_ack[1];
  assign c0_err    = r_err[0];
  assign c1_err    = r_err[1];
  assign c0_rdata  = r_rdata0;
  assign c1_rdata  = r_rdata1;
  assign f_rd_req  = r_f_req[0];
  assign f_pp_req  = r_f_req[1];
  assign f_se_req  = r_f_req[2];
  assign f_be_req  = r_f_req[3];
  assign f_rd_addr = r_f_addr;
  assign f_wr_addr = r_f_addr;
  assign f_se_addr = r_f_addr;
  assign f_wdata   = r_f_wdata;
  assign busy      = r_busy;
  assign grant_id  = r_gid;

  // Next-state logic for the operation sequencer.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any_req)          w_next = S_GRANT;
      S_GRANT:                         w_next = S_WAIT;
      S_WAIT:  if (f_ack || w_timeout) w_next = S_DONE;
      S_DONE:                          w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: every register is reset here because each one drives or feeds an
      // output that must read 0 right after the first reset edge.
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= 1'b0;
      r_gid     <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_req   <= '0;
      r_f_addr  <= '0;
      r_f_wdata <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gid   <= w_sel;
            r_cmd   <= w_sel ? c1_cmd   : c0_cmd;
            r_addr  <= w_sel ? c1_addr  : c0_addr;
            r_wdata <= w_sel ? c1_wdata : c0_wdata;
          end
        end
        S_GRANT: begin
          r_f_req   <= 4'b0001 << r_cmd;
          r_f_addr  <= r_addr;
          r_f_wdata <= r_wdata;
          r_cnt     <= '0;
        end
        S_WAIT: begin
          if (f_ack || w_timeout) begin
            // f_ack takes priority over a coincident timeout.
            r_f_req      <= '0;
            r_ack[r_gid] <= 1'b1;
            r_err[r_gid] <= ~f_ack;
            if (f_ack && (r_cmd == CMD_READ)) begin
              if (r_gid) r_rdata1 <= f_rdata;
              else       r_rdata0 <= f_rdata;
            end
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        S_DONE: begin
          r_ack <= '0;
          r_err <= '0;
          r_ptr <= ~r_gid;
        end
        default: ;
      endcase
    end
  end

endmodule
